// File: rtl/ifu_pkg.sv
// Shared FSM state type, fetch-buffer entry layout and ISA constants for instr_fetch_unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INSTR_SIZE = 32'd4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; head readable combinationally (zero read latency).
// A push on full is taken only alongside a pop; flush overrides both push and pop.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_dat,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head_dat,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, FIFO_DEPTH-entry prefetch buffer, branch flush.
// Request issues the cycle a buffer slot is free; define IFU_PERF_CNT_EN to add perf_fetch_cnt.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt
`endif
);
    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RV_ALIGNED = RESET_VECTOR & ~32'h3;

    ifu_state_e    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_br_pc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_inflight;
    logic          w_empty;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    fetch_ent_t    w_push_ent;
    fetch_ent_t    w_head;

    assign w_br_pc    = br_target & ~32'h3;
    assign w_inflight = (r_state == WAIT || r_state == DRAIN) ? CW'(1) : '0;
    assign w_issue    = (r_state == FETCH) && !br_taken &&
                        ((CW'(FIFO_DEPTH) - w_count) > w_inflight);
    // A redirect in the same cycle kills both the returning word and the decode handshake.
    assign w_push     = (r_state == WAIT) && mem_rvalid && !br_taken;
    assign w_pop      = if_valid && if_ready && !br_taken;
    assign w_push_ent = '{pc: r_fetch_pc, instr: mem_rdata};

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_ent_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (br_taken),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    assign mem_req  = w_issue;
    assign mem_addr = r_fetch_pc;
    assign if_valid = !w_empty;
    assign if_instr = w_head.instr;
    assign if_pc    = w_head.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RV_ALIGNED;
        end else begin
            if (br_taken)    r_fetch_pc <= w_br_pc;
            else if (w_push) r_fetch_pc <= r_fetch_pc + INSTR_SIZE;
            case (r_state)
                IDLE:    r_state <= FETCH;
                FETCH:   if (w_issue) r_state <= WAIT;
                WAIT: begin
                    if (mem_rvalid)    r_state <= FETCH;
                    else if (br_taken) r_state <= DRAIN;
                end
                DRAIN:   if (mem_rvalid) r_state <= FETCH;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     r_perf_cnt <= '0;
        else if (w_pop) r_perf_cnt <= r_perf_cnt + 32'd1;
    end

    assign perf_fetch_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written redirect/reset sequences, random run vs in-order delivery model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RV_B  = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        mem_req, mem_rvalid, if_valid, if_ready, br_taken;
    logic [31:0] mem_addr, mem_rdata, br_target, if_instr, if_pc;
    logic        b_mem_req, b_mem_rvalid, b_if_valid;
    logic [31:0] b_mem_addr, b_mem_rdata, b_if_instr, b_if_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, b_perf_fetch_cnt;
`endif

    instr_fetch_unit #(.RESET_VECTOR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .br_taken(br_taken),
        .br_target(br_target), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt)
`endif
    );

    instr_fetch_unit #(.RESET_VECTOR(RV_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata), .br_taken(br_taken),
        .br_target(br_target), .if_valid(b_if_valid), .if_ready(if_ready),
        .if_instr(b_if_instr), .if_pc(b_if_pc)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(b_perf_fetch_cnt)
`endif
    );

    int n_cmp = 0, n_bad = 0, cyc_n = 0, n_req = 0, lat = 1, rv_cyc = 0, acc_cnt = 0;
    logic        rand_lat = 1'b0, pend = 1'b0, b_pend = 1'b0, b_log = 1'b0;
    logic [31:0] pend_addr = '0, b_addr = '0, exp_pc = '0;
    logic        prev_br = 1'b0, prev_hold = 1'b0;
    logic [31:0] prev_pc = '0, prev_instr = '0;
    logic [31:0] b_addrs [$];

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample 1ns later, update memory and model.
    task automatic step(input logic rdy, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        cyc_n++;
        if_ready  = rdy;
        br_taken  = br;
        br_target = tgt;
        if (pend && cyc_n == rv_cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memf(pend_addr);
            pend       = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEAD_BEEF;
        end
        b_mem_rvalid = b_pend;
        b_mem_rdata  = b_pend ? memf(b_addr) : 32'hDEAD_BEEF;
        b_pend       = 1'b0;
        #1;
        if (prev_br) chk1("flush_clears_valid", if_valid, 1'b0);
        if (prev_hold) begin
            chk1("hold_valid", if_valid, 1'b1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
`ifdef IFU_PERF_CNT_EN
        chk("perf_cnt", perf_fetch_cnt, 32'(acc_cnt));
`endif
        if (if_valid && rdy && !br) begin
            chk("deliver_pc", if_pc, exp_pc);
            chk("deliver_instr", if_instr, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            acc_cnt++;
        end
        if (br) begin
            exp_pc = tgt & ~32'h3;
            chk1("no_req_on_branch", mem_req, 1'b0);
        end
        if (mem_req) begin
            n_req++;
            chk1("one_outstanding", pend, 1'b0);
            chk("addr_align", mem_addr & 32'h3, 32'h0);
            pend      = 1'b1;
            pend_addr = mem_addr;
            rv_cyc    = cyc_n + (rand_lat ? int'($urandom_range(1, 4)) : lat);
        end
        if (b_mem_req) begin
            b_pend = 1'b1;
            b_addr = b_mem_addr;
            if (b_log) b_addrs.push_back(b_mem_addr);
        end
        prev_br    = br;
        prev_hold  = if_valid && !rdy && !br;
        prev_pc    = if_pc;
        prev_instr = if_instr;
    endtask

    // Reset is held for a few cycles with a stray mem_rvalid that must be ignored.
    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b0; if_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        b_mem_rvalid = 1'b1; b_mem_rdata = 32'h0BAD_0BAD;
        pend = 1'b0; b_pend = 1'b0;
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_addr_b", b_mem_addr, RV_B);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf", perf_fetch_cnt, 32'h0);
        chk("rst_perf_b", b_perf_fetch_cnt, 32'h0);
`endif
        repeat (hold) @(negedge clk);
        chk1("rst_rvalid_ignored", if_valid, 1'b0);
        mem_rvalid = 1'b0; b_mem_rvalid = 1'b0;
        reset = 1'b1;
        exp_pc = '0; acc_cnt = 0; prev_br = 1'b0; prev_hold = 1'b0; cyc_n = 0; n_req = 0;
    endtask

    initial begin
        logic        got;
        logic [31:0] rv_exp [3];
        logic [31:0] b_a;
        reset = 1'b0; if_ready = 1'b0; br_taken = 1'b0; br_target = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; b_mem_rvalid = 1'b0; b_mem_rdata = '0;

        // Cycle k after reset release, memory latency 1, decode always ready.
        tbl[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        tbl[5] = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
        tbl[7] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h0};
        tbl[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};
        tbl[9] = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h0};
        rv_exp[0] = 32'hFFFF_FFF8; rv_exp[1] = 32'hFFFF_FFFC; rv_exp[2] = 32'h0000_0000;

        do_reset(3);
        b_log = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rdy, 1'b0, 32'h0);
            chk1("tbl_mem_req", mem_req, tbl[i].req);
            chk("tbl_mem_addr", mem_addr, tbl[i].addr);
            chk1("tbl_if_valid", if_valid, tbl[i].vld);
            if (tbl[i].vld) chk("tbl_if_pc", if_pc, tbl[i].pc);
            if (i == 8) begin
                chk1("wrap_b_valid", b_if_valid, 1'b1);
                chk("wrap_b_pc", b_if_pc, 32'h4);
                chk("wrap_b_instr", b_if_instr, memf(32'h4));
            end
        end
        b_log = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_a = (i < b_addrs.size()) ? b_addrs[i] : 32'h1;
            chk("wrap_b_addr", b_a, rv_exp[i]);
        end

        // Decode stalled: the buffer fills, then requests stop.
        do_reset(2);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 32'h0);
            if (k >= 6) chk1("stall_no_req", mem_req, 1'b0);
        end
        chk("stall_req_count", 32'(n_req), 32'(DEPTH));
        chk1("stall_valid", if_valid, 1'b1);
        chk("stall_pc", if_pc, 32'h0);
        chk("stall_instr", if_instr, memf(32'h0));
        repeat (12) step(1'b1, 1'b0, 32'h0);

        // Redirect while waiting on a slow memory: the late word is dropped.
        do_reset(2);
        lat = 3;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0103);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk1("drained_word_hidden", if_valid, 1'b0);
            if (mem_req) begin
                got = 1'b1;
                chk("redirect_addr", mem_addr, 32'h100);
            end
        end
        chk1("redirect_req_seen", got, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (if_valid) begin
                got = 1'b1;
                chk("redirect_pc", if_pc, 32'h100);
            end
        end
        chk1("redirect_valid_seen", got, 1'b1);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Redirect in the same cycle the word returns.
        do_reset(2);
        lat = 2;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0040);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b1, 1'b0, 32'h0);
            if (if_valid) begin
                got = 1'b1;
                chk("coincide_pc", if_pc, 32'h40);
            end
        end
        chk1("coincide_valid_seen", got, 1'b1);
        repeat (6) step(1'b1, 1'b0, 32'h0);

        // Five accepted handshakes, one flushed pop, then reset while waiting on memory.
        do_reset(2);
        lat = 3;
        for (int i = 0; i < 80 && acc_cnt < 5; i++) step(1'b1, 1'b0, 32'h0);
        chk("five_accepted", 32'(acc_cnt), 32'd5);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0);
            got = if_valid;
        end
        chk1("flush_pop_valid_seen", got, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("perf_after_flushed_pop", perf_fetch_cnt, 32'd5);
`endif
        got = mem_req;
        for (int i = 0; i < 8 && !got; i++) begin
            step(1'b0, 1'b0, 32'h0);
            got = mem_req;
        end
        chk1("midwait_req_seen", got, 1'b1);
        step(1'b0, 1'b0, 32'h0);
        do_reset(2);
        step(1'b0, 1'b0, 32'h0);
        chk("after_midwait_reset_addr", mem_addr, 32'h0);

        // Random traffic checked against in-order delivery from the last redirect.
        do_reset(2);
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, prefetch buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port mem_addr  output  32  byte address of the requested word, bits [1:0] always 2'b00.
REQ-007 SHALL have port mem_rvalid  input  1  memory returns the instruction word this cycle.
REQ-008 SHALL have port mem_rdata  input  32  instruction word, byte-little-endian assembled by memory.
REQ-009 SHALL have port br_taken  input  1  redirect request from execute.
REQ-010 SHALL have port br_target  input  32  redirect address; bits [1:0] are ignored.
REQ-011 SHALL have port if_valid  output  1  if_instr/if_pc hold a valid instruction.
REQ-012 SHALL have port if_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port if_instr  output  32  instruction to decode.
REQ-014 SHALL have port if_pc  output  32  address of if_instr.

Function
REQ-015 SHALL keep at most one memory request outstanding; mem_req is a one-cycle pulse, and the response arrives one or more cycles later on mem_rvalid.
REQ-016 SHALL use a state machine with states IDLE, FETCH, WAIT and DRAIN; IDLE is the reset state, and IDLE->FETCH occurs on the first clock after reset deasserts.
REQ-017 SHALL, in FETCH, pulse mem_req with mem_addr=fetch_pc when buffer free entries exceed the in-flight count, then go to WAIT; otherwise it SHALL remain in FETCH.
REQ-018 SHALL, in WAIT on mem_rvalid, push {fetch_pc, mem_rdata} into the buffer, set fetch_pc+=4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), and return to FETCH.
REQ-019 SHALL present the buffer head on if_valid/if_instr/if_pc; a pop occurs only when if_valid and if_ready are both high; if_instr/if_pc SHALL stay stable while if_valid is high and if_ready is low.
REQ-020 SHALL, on br_taken, flush the buffer the same cycle (if_valid low the next cycle) and set fetch_pc={br_target[31:2],2'b00}.
REQ-021 SHALL, on br_taken in WAIT with no mem_rvalid that cycle, go to DRAIN; in DRAIN the next mem_rvalid is discarded and the FSM goes to FETCH.
REQ-022 SHALL, on br_taken coincident with mem_rvalid, discard the returned word and go directly to FETCH.
REQ-023 SHALL give br_taken priority over push and pop in the same cycle; a pop in that cycle is not counted as accepted.
REQ-024 SHALL handle a push and a pop in the same cycle on a full buffer without loss or overflow.
REQ-025 SHALL not issue a new request in the cycle br_taken is high; the first redirected request issues no earlier than the next cycle.

Reset
REQ-026 SHALL, while reset is low, set state=IDLE, fetch_pc=RESET_VECTOR, buffer empty, mem_req=0, mem_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0.
REQ-027 SHALL abandon an outstanding request when reset asserts mid-operation; a mem_rvalid during reset SHALL be ignored.

Configuration
REQ-028 SHALL, with IFU_PERF_CNT_EN defined, add output perf_fetch_cnt (32 bits): reset 0, +1 per accepted if_valid&&if_ready handshake, wrapping at 2^32; without the macro, the port and counter SHALL not exist.

Structure
REQ-029 SHALL place the FSM state enum, the value 32'd4 used as the instruction-size constant, and the NOP encoding 32'h0000_0013 in shared package ifu_pkg.
REQ-030 SHALL implement the prefetch buffer as sub-module ifu_fifo (synchronous FIFO with flush, parameterised depth and width).

Verification
REQ-031 SHALL check: reset release, memory 1-cycle latency, if_ready=1 -> mem_addr sequence 0,4,8,...; if_pc matches mem_addr; first if_valid on cycle 3.
REQ-032 SHALL check: if_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then mem_req stays 0; if_instr is held stable.
REQ-033 SHALL check: br_taken with br_target=32'h0000_0103 during WAIT, memory latency 3 -> late word dropped; next mem_addr=32'h100; if_pc=32'h100.
REQ-034 SHALL check: br_taken coincident with mem_rvalid -> that word is never presented; fetch resumes at target.
REQ-035 SHALL check: RESET_VECTOR=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 SHALL check: with IFU_PERF_CNT_EN defined, 5 accepted handshakes and 1 flushed pop -> perf_fetch_cnt=5; reset mid-WAIT -> count=0, if_valid=0.
